// File: rtl/addr_scan_reader.sv
// Address scanner: walks ptr from 0 to ADDR_MAX and issues one read per advance
// event. The latest completed read is held on disp_*. Timeouts and dropped events set err.
module addr_scan_reader #(
    parameter int ADDR_W      = 8,
    parameter int ADDR_MAX    = 255,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              run,
    input  logic              step_btn,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [31:0]       rd_data,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [31:0]       disp_data,
    output logic              disp_valid,
    output logic              err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic {IDLE, REQ} state_t;

    state_t            state, state_nx;
    logic              step_s1, step_s2, step_s3;
    logic              step_evt, adv_evt;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic [TW-1:0]     tcnt;
    logic              pending, pend_nx;
    logic              issue, complete, timeout, drop;

    // step_s3 holds the previous synchronized value for rising-edge detection
    assign step_evt = step_s2 & ~step_s3;
    assign adv_evt  = (tick & run) | step_evt;
    assign ptr_nx   = (ptr == ADDR_W'(ADDR_MAX)) ? '0 : ptr + ADDR_W'(1);

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        drop     = 1'b0;
        pend_nx  = pending;
        case (state)
            IDLE: begin
                if (adv_evt) begin
                    issue    = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                // An event arriving in the exit cycle also counts as pending
                drop    = adv_evt & pending;
                pend_nx = pending | adv_evt;
                if (rd_ack) begin
                    complete = 1'b1;
                end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
                    timeout = 1'b1;
                end
                if (complete || timeout) begin
                    if (pend_nx) begin
                        issue   = 1'b1;
                        pend_nx = 1'b0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            step_s1    <= 1'b0;
            step_s2    <= 1'b0;
            step_s3    <= 1'b0;
            ptr        <= '0;
            tcnt       <= '0;
            pending    <= 1'b0;
            rd_req     <= 1'b0;
            rd_addr    <= '0;
            disp_addr  <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            step_s1    <= step_btn;
            step_s2    <= step_s1;
            step_s3    <= step_s2;
            pending    <= pend_nx;
            disp_valid <= complete;
            if (complete) begin
                disp_addr <= rd_addr;
                disp_data <= rd_data;
            end
            if (issue) begin
                rd_req  <= 1'b1;
                rd_addr <= ptr;
                ptr     <= ptr_nx;
                tcnt    <= '0;
            end else if (complete || timeout) begin
                rd_req <= 1'b0;
            end else if (state == REQ) begin
                tcnt <= tcnt + TW'(1);
            end
            if (timeout || drop) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_addr_scan_reader.sv
// Bench for addr_scan_reader: two instances (ADDR_MAX 255 and 3) share stimulus
// and are compared every cycle against a transaction-level reference model.
module tb_addr_scan_reader;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n, tick, run, step_btn, rd_ack;
    logic [31:0] rd_data;

    logic        rd_req0, rd_req1, dv0, dv1, err0, err1;
    logic [7:0]  rd_addr0, rd_addr1, da0, da1;
    logic [31:0] dd0, dd1;

    int vectors = 0;
    int miscompares = 0;

    // reference model state, index 0 = default instance, 1 = ADDR_MAX 3
    int          amax[2] = '{255, 3};
    bit          m_busy[2], m_pend[2], m_err[2], m_dv[2];
    int          m_addr[2], m_age[2], m_ptr[2], m_da[2];
    logic [31:0] m_dd[2];
    bit          samp[3];

    addr_scan_reader dut0 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .step_btn(step_btn),
        .rd_req(rd_req0), .rd_addr(rd_addr0), .rd_ack(rd_ack), .rd_data(rd_data),
        .disp_addr(da0), .disp_data(dd0), .disp_valid(dv0), .err(err0)
    );

    addr_scan_reader #(.ADDR_W(8), .ADDR_MAX(3), .ACK_TIMEOUT(TO)) dut1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .step_btn(step_btn),
        .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_ack(rd_ack), .rd_data(rd_data),
        .disp_addr(da1), .disp_data(dd1), .disp_valid(dv1), .err(err1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently applied
    task automatic model_edge();
        bit sevt, evt, ex, p2;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 0; m_pend[i] = 0; m_err[i] = 0; m_dv[i] = 0;
                m_addr[i] = 0; m_age[i] = 0; m_ptr[i] = 0; m_da[i] = 0; m_dd[i] = '0;
            end
            samp = '{0, 0, 0};
            return;
        end
        // a step event is a 0->1 change seen two and three samples back
        sevt = samp[1] && !samp[2];
        samp[2] = samp[1];
        samp[1] = samp[0];
        samp[0] = step_btn;
        evt = (tick && run) || sevt;
        for (int i = 0; i < 2; i++) begin
            m_dv[i] = 0;
            if (!m_busy[i]) begin
                if (evt) begin
                    m_busy[i] = 1;
                    m_addr[i] = m_ptr[i];
                    m_age[i]  = 0;
                    m_ptr[i]  = (m_ptr[i] == amax[i]) ? 0 : m_ptr[i] + 1;
                end
            end else begin
                ex = 0;
                if (rd_ack) begin
                    m_dv[i] = 1; m_da[i] = m_addr[i]; m_dd[i] = rd_data; ex = 1;
                end else if (m_age[i] + 1 >= TO) begin
                    m_err[i] = 1; ex = 1;
                end else begin
                    m_age[i]++;
                end
                if (evt && m_pend[i]) m_err[i] = 1;
                p2 = m_pend[i] || evt;
                if (ex && p2) begin
                    m_addr[i] = m_ptr[i];
                    m_age[i]  = 0;
                    m_ptr[i]  = (m_ptr[i] == amax[i]) ? 0 : m_ptr[i] + 1;
                    m_pend[i] = 0;
                end else if (ex) begin
                    m_busy[i] = 0;
                    m_pend[i] = 0;
                end else begin
                    m_pend[i] = p2;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("rd_req0", {31'b0, rd_req0}, {31'b0, m_busy[0]});
        chk("rd_addr0", {24'b0, rd_addr0}, 32'(m_addr[0]));
        chk("disp_valid0", {31'b0, dv0}, {31'b0, m_dv[0]});
        chk("disp_addr0", {24'b0, da0}, 32'(m_da[0]));
        chk("disp_data0", dd0, m_dd[0]);
        chk("err0", {31'b0, err0}, {31'b0, m_err[0]});
        chk("rd_req1", {31'b0, rd_req1}, {31'b0, m_busy[1]});
        chk("rd_addr1", {24'b0, rd_addr1}, 32'(m_addr[1]));
        chk("disp_valid1", {31'b0, dv1}, {31'b0, m_dv[1]});
        chk("disp_addr1", {24'b0, da1}, 32'(m_da[1]));
        chk("disp_data1", dd1, m_dd[1]);
        chk("err1", {31'b0, err1}, {31'b0, m_err[1]});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input bit t, input bit r, input bit s, input bit a, input logic [31:0] d);
        tick = t; run = r; step_btn = s; rd_ack = a; rd_data = d;
        cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; tick = 0; run = 0; step_btn = 0; rd_ack = 0; rd_data = '0;

        // reset state
        drive(0, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 1, 32'hdead_beef);
        chk("reset_rd_req", {31'b0, rd_req0}, 32'h0);
        chk("reset_err", {31'b0, err0}, 32'h0);
        rst_n = 1'b1;

        // single tick, ack two cycles after rd_req
        drive(1, 1, 0, 0, 32'h0);
        chk("t1_rd_req", {31'b0, rd_req0}, 32'h1);
        chk("t1_rd_addr", {24'b0, rd_addr0}, 32'h0);
        drive(0, 1, 0, 0, 32'h0);
        drive(0, 1, 0, 1, 32'h1234_5678);
        chk("t1_disp_valid", {31'b0, dv0}, 32'h1);
        chk("t1_disp_data", dd0, 32'h1234_5678);
        chk("t1_disp_addr", {24'b0, da0}, 32'h0);
        drive(0, 1, 0, 0, 32'h0);
        chk("t1_disp_valid_off", {31'b0, dv0}, 32'h0);
        drive(1, 1, 0, 0, 32'h0);
        chk("t1_next_addr", {24'b0, rd_addr0}, 32'h1);
        drive(0, 1, 0, 1, 32'h0000_0001);

        // wrap with ADDR_MAX=3
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 0, 0, 32'h0);
            chk("wrap_addr", {24'b0, rd_addr1}, 32'(k % 4));
            drive(0, 1, 0, 1, 32'h100 + 32'(k));
        end
        chk("wrap_err", {31'b0, err1}, 32'h0);

        // run=0 ignores ticks, step button gives exactly one read
        for (int k = 0; k < 6; k++) drive(k[0], 0, 0, 0, 32'h0);
        chk("paused_rd_req", {31'b0, rd_req0}, 32'h0);
        for (int k = 0; k < 10; k++) begin
            drive(k[0], 0, 1, (k == 5) ? 1'b1 : 1'b0, 32'hcafe_0000);
            if (k < 2) chk("step_early", {31'b0, rd_req0}, 32'h0);
            if (k == 2) chk("step_rise", {31'b0, rd_req0}, 32'h1);
        end
        for (int k = 0; k < 5; k++) drive(0, 0, 0, 0, 32'h0);

        // ack never comes
        do_reset();
        drive(1, 1, 0, 0, 32'h0);
        for (int k = 0; k < 14; k++) drive(0, 1, 0, 0, 32'h0);
        chk("to_still_req", {31'b0, rd_req0}, 32'h1);
        drive(0, 1, 0, 0, 32'h0);
        chk("to_rd_req", {31'b0, rd_req0}, 32'h0);
        chk("to_err", {31'b0, err0}, 32'h1);
        chk("to_disp_data", dd0, 32'h0);
        for (int k = 0; k < 3; k++) drive(0, 1, 0, 0, 32'h0);

        // two ticks during one outstanding read
        do_reset();
        drive(1, 1, 0, 0, 32'h0);
        drive(1, 1, 0, 0, 32'h0);
        chk("pend_err_clear", {31'b0, err0}, 32'h0);
        drive(1, 1, 0, 0, 32'h0);
        chk("drop_err", {31'b0, err0}, 32'h1);
        drive(0, 1, 0, 1, 32'haaaa_0000);
        chk("b2b_rd_req", {31'b0, rd_req0}, 32'h1);
        chk("b2b_rd_addr", {24'b0, rd_addr0}, 32'h1);
        drive(0, 1, 0, 1, 32'hbbbb_0001);
        drive(0, 1, 0, 0, 32'h0);
        chk("b2b_done", {31'b0, rd_req0}, 32'h0);

        // reset mid-read
        do_reset();
        drive(1, 1, 0, 0, 32'h0);
        drive(0, 1, 0, 0, 32'h0);
        rst_n = 1'b0;
        drive(0, 1, 0, 1, 32'h5555_5555);
        rst_n = 1'b1;
        drive(0, 1, 0, 1, 32'h6666_6666);
        chk("rst_mid_dv", {31'b0, dv0}, 32'h0);
        chk("rst_mid_req", {31'b0, rd_req0}, 32'h0);
        chk("rst_mid_data", dd0, 32'h0);
        drive(1, 1, 0, 0, 32'h0);
        chk("rst_mid_addr", {24'b0, rd_addr0}, 32'h0);

        // randomized traffic in phases with different ack rates
        for (int ph = 0; ph < 4; ph++) begin
            int ack_pct;
            ack_pct = (ph == 2) ? 3 : 20 + ph * 20;
            for (int k = 0; k < 800; k++) begin
                rst_n = ($urandom_range(0, 199) != 0);
                if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
                drive($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, step_btn,
                      $urandom_range(0, 99) < ack_pct, $urandom);
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) drive(0, 0, 0, 1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/addr_scan_reader.md
ADDR_SCAN_READER -- requirements
Module: addr_scan_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address width.
REQ-002 SHALL have parameter ADDR_MAX, default 255, last scanned address, then wrap to 0.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 15, max cycles in REQ before abort.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 tick  input  1  one-cycle advance pulse from the slow-tick divider.
REQ-007 run  input  1  level; 1 = auto-scan on tick, 0 = paused.
REQ-008 step_btn  input  1  raw asynchronous manual-step button, already debounced externally.
REQ-009 rd_req  output  1  read request to memory/register-file read port.
REQ-010 rd_addr  output  ADDR_W  read address, stable while rd_req=1.
REQ-011 rd_ack  input  1  one-cycle read acknowledge; rd_data valid in same cycle.
REQ-012 rd_data  input  32  read data.
REQ-013 disp_addr  output  ADDR_W  address of last completed read.
REQ-014 disp_data  output  32  data of last completed read.
REQ-015 disp_valid  output  1  one-cycle pulse when disp_addr/disp_data update.
REQ-016 err  output  1  sticky: a read timed out or an event was dropped.

Function
REQ-017 step_btn SHALL pass through a 2-flop synchronizer plus one edge-detect flop; rising edge of synchronized signal = step event.
REQ-018 Advance event SHALL be (tick & run) | step event, evaluated combinationally each cycle.
REQ-019 FSM SHALL have states IDLE, REQ; reset state IDLE.
REQ-020 IDLE + event at cycle n: rd_addr <= ptr, rd_req <= 1 at edge ending cycle n, state -> REQ, ptr advances.
REQ-021 ptr advance: ptr == ADDR_MAX -> 0, else ptr+1; no out-of-range value ever driven on rd_addr.
REQ-022 REQ + rd_ack=1: disp_data <= rd_data, disp_addr <= rd_addr, disp_valid=1 for exactly the next cycle, rd_req <= 0, state -> IDLE.
REQ-023 rd_req SHALL stay 1 and rd_addr constant from REQ entry until ack or timeout.
REQ-024 Timeout counter SHALL clear on REQ entry and increment each REQ cycle without ack; reaching ACK_TIMEOUT cycles -> rd_req <= 0, err <= 1, disp_* unchanged, disp_valid stays 0, state -> IDLE.
REQ-025 rd_ack in the timeout cycle SHALL win: treated as normal completion, err not set.
REQ-026 rd_ack while in IDLE SHALL be ignored.
REQ-027 Event during REQ: if pending flag clear, set it; if already set, drop event and set err.
REQ-028 On REQ -> IDLE (ack or timeout) with pending set: clear pending and issue next read immediately (rd_req remains 1, new rd_addr = ptr, REQ re-entered, timeout counter cleared).
REQ-029 Event in same cycle as REQ exit: counted as pending, served per REQ-028.
REQ-030 run=0 SHALL suppress tick events only; step events still operate.
REQ-031 err SHALL clear only on reset.

Reset
REQ-032 rst_n=0 sampled at a rising edge SHALL force: state IDLE, ptr=0, rd_req=0, rd_addr=0, disp_addr=0, disp_data=0, disp_valid=0, err=0, pending=0, timeout counter=0, synchronizer/edge flops=0.
REQ-033 Reset mid-REQ SHALL abort the read with no disp_valid pulse; rd_ack arriving during or the cycle after reset ignored.
REQ-034 rst_n deassertion takes effect at the next edge; no event accepted in the cycle rst_n is low.

Verification
REQ-035 run=1, tick pulse, rd_ack 2 cycles after rd_req with rd_data=32'h1234_5678 -> rd_addr=0, disp_addr=0, disp_data=32'h1234_5678, one disp_valid pulse, next tick reads addr 1.
REQ-036 ADDR_MAX=3, 5 ticks each acked -> rd_addr sequence 0,1,2,3,0; err=0.
REQ-037 run=0, ticks applied, then step_btn high for 10 cycles -> no reads from ticks; exactly one read, rd_req rises at the 3rd edge sampling step_btn=1.
REQ-038 rd_ack never asserted -> rd_req deasserts after 15 cycles, err=1, disp_valid never pulses, disp_data unchanged.
REQ-039 Two ticks during one outstanding REQ -> first served back-to-back after ack (rd_req stays high), second dropped, err=1.
REQ-040 rst_n low for 1 cycle mid-REQ, then rd_ack -> all outputs at reset values, no disp_valid, next tick reads addr 0.
